// File: rtl/correlator_sdiv_seq.sv
// Sequential radix-2 restoring signed divider: one quotient bit per clock, valid/ready on both
// sides, quotient truncated toward zero and remainder carrying the dividend's sign.
module correlator_sdiv_seq #(
  parameter int unsigned DIVIDEND_WIDTH = 32,
  parameter int unsigned DIVISOR_WIDTH  = 16
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero,
  output logic                      overflow
);

  localparam int unsigned CW = $clog2(DIVIDEND_WIDTH + 1);
  localparam int unsigned PW = DIVISOR_WIDTH + 1;
  localparam logic [DIVIDEND_WIDTH-1:0] QMIN = {1'b1, {(DIVIDEND_WIDTH-1){1'b0}}};
  localparam logic [DIVIDEND_WIDTH-1:0] QMAX = ~QMIN;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                     state_q, state_d;
  logic [PW-1:0]              part_q, part_d;
  // Holds |dividend| as unsigned (|MIN| fits exactly); quotient bits shift in from the LSB.
  logic [DIVIDEND_WIDTH-1:0]  dvd_q, dvd_d;
  logic [DIVISOR_WIDTH-1:0]   dsr_q, dsr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       qneg_q, qneg_d, rneg_q, rneg_d;
  logic                       dz_q, dz_d, ov_q, ov_d;
  logic [DIVISOR_WIDTH-1:0]   low_q, low_d;
  logic [DIVIDEND_WIDTH-1:0]  quo_q, quo_d;
  logic [DIVISOR_WIDTH-1:0]   rem_q, rem_d;
  logic                       dbz_q, dbz_d, ovf_q, ovf_d;

  logic [PW:0]                shifted, diff;
  logic                       qbit;
  logic [DIVISOR_WIDTH-1:0]   rem_mag;

  assign shifted = {part_q, dvd_q[DIVIDEND_WIDTH-1]};
  assign diff    = shifted - (PW+1)'(dsr_q);
  assign qbit    = shifted >= (PW+1)'(dsr_q);
  assign rem_mag = DIVISOR_WIDTH'(part_q);

  always_comb begin
    state_d = state_q;
    part_d  = part_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    low_d   = low_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (s_valid) begin
          dvd_d   = dividend[DIVIDEND_WIDTH-1] ? -dividend : dividend;
          dsr_d   = divisor[DIVISOR_WIDTH-1] ? -divisor : divisor;
          part_d  = '0;
          cnt_d   = CW'(DIVIDEND_WIDTH);
          qneg_d  = dividend[DIVIDEND_WIDTH-1] ^ divisor[DIVISOR_WIDTH-1];
          rneg_d  = dividend[DIVIDEND_WIDTH-1];
          dz_d    = (divisor == '0);
          ov_d    = (dividend == QMIN) && (divisor == '1);
          low_d   = dividend[DIVISOR_WIDTH-1:0];
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          part_d = qbit ? PW'(diff) : PW'(shifted);
          dvd_d  = {dvd_q[DIVIDEND_WIDTH-2:0], qbit};
          cnt_d  = cnt_q - CW'(1);
        end else begin
          // Sign fix-up and special-case override, registered on the way into DONE.
          dbz_d = dz_q;
          ovf_d = ov_q;
          if (dz_q) begin
            quo_d = rneg_q ? QMIN : QMAX;
            rem_d = low_q;
          end else if (ov_q) begin
            quo_d = QMIN;
            rem_d = '0;
          end else begin
            quo_d = qneg_q ? -dvd_q : dvd_q;
            rem_d = rneg_q ? -rem_mag : rem_mag;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        if (m_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= StIdle;
      part_q  <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      low_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      part_q  <= part_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      low_q   <= low_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign s_ready     = (state_q == StIdle) && !ap_rst;
  assign m_valid     = (state_q == StDone);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
